mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter sharing one single-port synchronous RAM between the CPU's instruction-fetch path, its data (LDA/STO/ALU operand) path and an external program loader. It accepts held requests, grants one per access, drives the RAM control pins, waits out the read latency and returns a one-cycle completion pulse with read data to the owner. It sits between the CPU control/datapath and the memory macro, replacing separate instruction and data memory enables.

## Interface
Parameters:
- `AW`, 5, address width.
- `DW`, 8, data width.
- `RD_WAIT`, 1, RAM read latency in cycles; legal 1..15.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  3  request per requester: [0] fetch, [1] data, [2] loader; held until `gnt`.
- `we`  in  3  per-requester write flag; fetch bit ignored (fetch always reads).
- `addr`  in  3×AW  per-requester address, packed, requester 0 in LSBs.
- `wdata`  in  3×DW  per-requester write data, packed.
- `gnt`  out  3  one-hot, one-cycle pulse: request accepted.
- `done`  out  3  one-hot, one-cycle pulse: access complete.
- `rdata`  out  DW  read data, valid when `done` for a read.
- `busy`  out  1  high in any state except IDLE.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data, valid RD_WAIT cycles after `mem_en` read cycle.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any `req` bit set, pick winner, register owner, `addr`, `we` (forced 0 for fetch), `wdata`; go to ACCESS. Otherwise stay.
- ACCESS (1 cycle): `mem_en`=1, `mem_we`=registered `we`, `mem_addr`/`mem_wdata` from registers; `gnt[owner]`=1. Write → RESP; read → WAIT, counter loaded with RD_WAIT.
- WAIT: counter decrements each cycle; on last cycle (counter==1) capture `mem_rdata` into `rdata`; go to RESP.
- RESP (1 cycle): `done[owner]`=1; go to IDLE. `rdata` holds until next read capture.
- Arbitration sampled only in IDLE; requests arriving in other states wait. A `req` dropped before its `gnt` is lost with no side effect. `req` bit of the owner is don't-care after `gnt`.
- Outside ACCESS: `mem_en`=0, `mem_we`=0; `mem_addr`/`mem_wdata` hold last registered values.
- Priority as selected in Configuration.
- Reset (any state, any time): state IDLE, `gnt`/`done`/`mem_en`/`mem_we`/`busy`=0, `rdata`/`mem_addr`/`mem_wdata`=0, owner=0, round-robin pointer=loader (fetch highest next). An aborted access produces no `done`.

## Timing
- Request visible in IDLE at cycle T: ACCESS and `gnt` at T+1.
- Write: `done` at T+2. Read: WAIT T+2..T+1+RD_WAIT, `done` and valid `rdata` at T+2+RD_WAIT.
- RESP→IDLE→ACCESS: back-to-back accesses start every 3 cycles (write) or 3+RD_WAIT (read); no overlap.
- `gnt` and `done` never both high in one cycle; at most one bit of each set.
- `busy` falls in the cycle after RESP.

## Configuration
- `MEMARB_RR_EN` defined: round-robin; search starts at requester after last granted owner, wrapping 2→0; pointer updates on entry to ACCESS.
- Undefined: fixed priority loader(2) > data(1) > fetch(0); no pointer state.

## Test plan
- Reset then fetch read: `req`=001, addr 5'h03, RAM[3]=8'hA5, RD_WAIT=1 -> `gnt`=001 at T+1, `done`=001 and `rdata`=8'hA5 at T+3.
- Data write: `req`=010, `we`=010, addr 5'h1F, wdata 8'h3C -> `mem_en`=`mem_we`=1, `mem_addr`=1F, `mem_wdata`=3C in ACCESS only; `done`=010 at T+2; later fetch of 1F returns 3C.
- All three requesting continuously from reset, reads: fixed build grants 100,100,...; `MEMARB_RR_EN` build grants 001,010,100,001 in successive accesses.
- RD_WAIT=3 read: `done` at T+5; `mem_rdata` changed before capture cycle ignored, value at T+4 returned.
- Fetch `we` bit set with `req`=001 -> `mem_we`=0, read performed.
- `rst_n` low during WAIT -> `mem_en`=0, `busy`=0 immediately, no `done`; after release, pending `req` re-granted from IDLE normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between fetch (0), data (1) and loader (2).
// Latency: gnt one cycle after a request is seen in IDLE; done at +2 (write) or +2+RD_WAIT (read).
// Backpressure: requests are held by the requester until gnt; one access in flight, others wait in IDLE.
// Build option: define MEMARB_RR_EN for round-robin arbitration, otherwise fixed loader > data > fetch.
module mem_port_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int RD_WAIT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [3:0]      cnt_q, cnt_d;

  // Arbitration result, only consumed while in IDLE.
  logic [1:0]      win;
  logic            win_vld;

`ifdef MEMARB_RR_EN
  // Last granted owner; the search starts just after it.
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      rr_idx;

  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin pick: walk the three requesters starting after the pointer.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    rr_idx  = rr_next(ptr_q);
    for (int i = 0; i < 3; i++) begin
      if (!win_vld && req[rr_idx]) begin
        win     = rr_idx;
        win_vld = 1'b1;
      end
      rr_idx = rr_next(rr_idx);
    end
  end

  // Pointer follows the owner chosen on the way into ACCESS.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win_vld) begin
      ptr_d = win;
    end
  end

  // Pointer register; after reset the loader counts as last owner so fetch goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd2;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority pick: loader beats data beats fetch.
  always_comb begin
    win     = 2'd0;
    win_vld = |req;
    if (req[2]) begin
      win = 2'd2;
    end else if (req[1]) begin
      win = 2'd1;
    end
  end
`endif

  // Sequencer: next state, captured request fields and RAM/handshake outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    gnt     = 3'b000;
    done    = 3'b000;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          owner_d = win;
          addr_d  = addr[int'(win)*AW +: AW];
          wdata_d = wdata[int'(win)*DW +: DW];
          // Fetch is read-only regardless of its write flag.
          we_d    = (win != 2'd0) && we[win];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        gnt    = 3'b001 << owner_q;
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = 4'(RD_WAIT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Earlier mem_rdata values are not yet the answer; sample only on the last wait cycle.
        if (cnt_q == 4'd1) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        done    = 3'b001 << owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses RD_WAIT=1, instance 1 uses RD_WAIT=3.
// Directed stimulus pushes expected grants/completions; a negedge monitor pops and compares.
// Bench RAM returns filler on mem_rdata except in the cycle the read answer is due.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a     [2];
  logic [2:0]  req_a       [2];
  logic [2:0]  we_a        [2];
  logic [14:0] addr_a      [2];
  logic [23:0] wdata_a     [2];
  logic [2:0]  gnt_a       [2];
  logic [2:0]  done_a      [2];
  logic [7:0]  rdata_a     [2];
  logic        busy_a      [2];
  logic        mem_en_a    [2];
  logic        mem_we_a    [2];
  logic [4:0]  mem_addr_a  [2];
  logic [7:0]  mem_wdata_a [2];
  logic [7:0]  mem_rdata_a [2];

  mem_port_arbiter #(.AW(5), .DW(8), .RD_WAIT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
    .wdata(wdata_a[0]), .gnt(gnt_a[0]), .done(done_a[0]), .rdata(rdata_a[0]),
    .busy(busy_a[0]), .mem_en(mem_en_a[0]), .mem_we(mem_we_a[0]),
    .mem_addr(mem_addr_a[0]), .mem_wdata(mem_wdata_a[0]), .mem_rdata(mem_rdata_a[0])
  );

  mem_port_arbiter #(.AW(5), .DW(8), .RD_WAIT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
    .wdata(wdata_a[1]), .gnt(gnt_a[1]), .done(done_a[1]), .rdata(rdata_a[1]),
    .busy(busy_a[1]), .mem_en(mem_en_a[1]), .mem_we(mem_we_a[1]),
    .mem_addr(mem_addr_a[1]), .mem_wdata(mem_wdata_a[1]), .mem_rdata(mem_rdata_a[1])
  );

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int         dut;
    logic [2:0] bits;
    int         cyc;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int rdw(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- RAM model ----------------
  bit   [7:0] ram     [2][32];
  bit         written [2][32];
  bit   [2:0] pv      [2];
  bit   [7:0] pd      [2][3];

  function automatic logic [7:0] init_val(input logic [4:0] a);
    case (a)
      5'h01:   return 8'h11;
      5'h02:   return 8'h22;
      5'h03:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input int k, input logic [4:0] a);
    return written[k][a] ? ram[k][a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (mem_en_a[k] && mem_we_a[k]) begin
        ram[k][mem_addr_a[k]]     <= mem_wdata_a[k];
        written[k][mem_addr_a[k]] <= 1'b1;
      end
      pv[k]    <= {pv[k][1:0], mem_en_a[k] && !mem_we_a[k]};
      pd[k][2] <= pd[k][1];
      pd[k][1] <= pd[k][0];
      pd[k][0] <= ram_rd(k, mem_addr_a[k]);
    end
  end

  logic [7:0] filler;
  assign filler         = {4'hE, 4'(cyc)};
  assign mem_rdata_a[0] = pv[0][0] ? pd[0][0] : filler;
  assign mem_rdata_a[1] = pv[1][2] ? pd[1][2] : filler;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (gnt_a[k] != 3'b000 && done_a[k] != 3'b000) chk("gnt_and_done", {29'd0, done_a[k]}, 0);
      if (gnt_a[k] != 3'b000) begin
        if (gq.size() == 0) chk("unexpected_gnt", {29'd0, gnt_a[k]}, 0);
        else begin
          mon_e = gq.pop_front();
          chk("gnt_dut", k, mon_e.dut);
          chk("gnt", {29'd0, gnt_a[k]}, {29'd0, mon_e.bits});
          chk("gnt_cycle", cyc, mon_e.cyc);
          chk("access_mem_en", {31'd0, mem_en_a[k]}, 1);
          chk("access_mem_we", {31'd0, mem_we_a[k]}, {31'd0, mon_e.we});
          chk("access_mem_addr", {27'd0, mem_addr_a[k]}, {27'd0, mon_e.addr});
          if (mon_e.we) chk("access_mem_wdata", {24'd0, mem_wdata_a[k]}, {24'd0, mon_e.wd});
        end
      end else begin
        chk("idle_mem_en_we", {30'd0, mem_en_a[k], mem_we_a[k]}, 0);
      end
      if (done_a[k] != 3'b000) begin
        if (dq.size() == 0) chk("unexpected_done", {29'd0, done_a[k]}, 0);
        else begin
          mon_e = dq.pop_front();
          chk("done_dut", k, mon_e.dut);
          chk("done", {29'd0, done_a[k]}, {29'd0, mon_e.bits});
          chk("done_cycle", cyc, mon_e.cyc);
          if (!mon_e.we) chk("rdata", {24'd0, rdata_a[k]}, {24'd0, mon_e.rd});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input int k);
    int n = 0;
    while (busy_a[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (busy_a[k]) chk("idle_timeout", {31'd0, busy_a[k]}, 0);
  endtask

  task automatic push_exp(input int k, input int r, input logic w, input logic [4:0] a,
                          input logic [7:0] d, input logic [7:0] rd, input int t, input bit with_done);
    exp_t e;
    e.dut  = k;
    e.bits = 3'(1 << r);
    e.cyc  = t + 1;
    e.we   = w;
    e.addr = a;
    e.wd   = d;
    e.rd   = rd;
    gq.push_back(e);
    e.cyc = w ? t + 2 : t + 2 + rdw(k);
    if (with_done) dq.push_back(e);
  endtask

  task automatic set_req(input int k, input int r, input logic w, input logic [4:0] a, input logic [7:0] d);
    req_a[k][r]          = 1'b1;
    we_a[k][r]           = w;
    addr_a[k][r*5 +: 5]  = a;
    wdata_a[k][r*8 +: 8] = d;
  endtask

  task automatic wait_gnt(input int k);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (gnt_a[k] == 3'b000 && n < 20);
    if (gnt_a[k] == 3'b000) chk("gnt_timeout", {31'd0, busy_a[k]}, 1);
  endtask

  // One complete access; exp_we is the RAM write flag the arbiter must drive.
  task automatic access(input int k, input int r, input logic w, input logic exp_we,
                        input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    wait_idle(k);
    set_req(k, r, w, a, d);
    push_exp(k, r, exp_we, a, d, exp_rd, cyc, 1'b1);
    wait_gnt(k);
    req_a[k][r] = 1'b0;
    we_a[k][r]  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int k);
    chk("rst_gnt", {29'd0, gnt_a[k]}, 0);
    chk("rst_done", {29'd0, done_a[k]}, 0);
    chk("rst_busy", {31'd0, busy_a[k]}, 0);
    chk("rst_mem_en", {31'd0, mem_en_a[k]}, 0);
    chk("rst_rdata", {24'd0, rdata_a[k]}, 0);
    chk("rst_mem_addr", {27'd0, mem_addr_a[k]}, 0);
    chk("rst_mem_wdata", {24'd0, mem_wdata_a[k]}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int ng;
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_n_a[k] = 1'b0;
      req_a[k]   = 3'b000;
      we_a[k]    = 3'b000;
      addr_a[k]  = '0;
      wdata_a[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst_n_a[0] = 1'b1;
    rst_n_a[1] = 1'b1;

    // All three requesters hold read requests from reset.
    set_req(0, 0, 1'b0, 5'h03, 8'h00);
    set_req(0, 1, 1'b0, 5'h01, 8'h00);
    set_req(0, 2, 1'b0, 5'h02, 8'h00);
    t = cyc;
`ifdef MEMARB_RR_EN
    push_exp(0, 0, 1'b0, 5'h03, 8'h00, 8'hA5, t,      1'b1);
    push_exp(0, 1, 1'b0, 5'h01, 8'h00, 8'h11, t + 4,  1'b1);
    push_exp(0, 2, 1'b0, 5'h02, 8'h00, 8'h22, t + 8,  1'b1);
    push_exp(0, 0, 1'b0, 5'h03, 8'h00, 8'hA5, t + 12, 1'b1);
`else
    for (int i = 0; i < 4; i++) push_exp(0, 2, 1'b0, 5'h02, 8'h00, 8'h22, t + 4 * i, 1'b1);
`endif
    ng = 0;
    n  = 0;
    while (ng < 4 && n < 60) begin
      @(posedge clk); #1; n++;
      if (gnt_a[0] != 3'b000) ng++;
    end
    if (ng < 4) chk("continuous_gnt_count", ng, 4);
    req_a[0] = 3'b000;

    // Single-requester accesses on the RD_WAIT=1 instance.
    access(0, 0, 1'b0, 1'b0, 5'h03, 8'h00, 8'hA5);
    access(0, 1, 1'b1, 1'b1, 5'h1F, 8'h3C, 8'h00);
    access(0, 0, 1'b0, 1'b0, 5'h1F, 8'h00, 8'h3C);
    access(0, 0, 1'b1, 1'b0, 5'h03, 8'h77, 8'hA5);
    access(0, 2, 1'b1, 1'b1, 5'h0A, 8'h5A, 8'h00);
    access(0, 1, 1'b0, 1'b0, 5'h0A, 8'h00, 8'h5A);

    // RD_WAIT=3 instance: filler on mem_rdata until the due cycle.
    access(1, 0, 1'b0, 1'b0, 5'h03, 8'h00, 8'hA5);
    access(1, 1, 1'b1, 1'b1, 5'h07, 8'h96, 8'h00);
    access(1, 2, 1'b0, 1'b0, 5'h07, 8'h00, 8'h96);

    // Reset during WAIT: no done, then the still-held request is granted afresh.
    wait_idle(0);
    set_req(0, 1, 1'b0, 5'h01, 8'h00);
    push_exp(0, 1, 1'b0, 5'h01, 8'h00, 8'h11, cyc, 1'b0);
    wait_gnt(0);
    @(posedge clk); #1;
    chk("abort_in_wait_busy", {31'd0, busy_a[0]}, 1);
    #1;
    rst_n_a[0] = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_a[0]}, 0);
    chk("abort_mem_en", {31'd0, mem_en_a[0]}, 0);
    chk("abort_rdata", {24'd0, rdata_a[0]}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n_a[0] = 1'b1;
    push_exp(0, 1, 1'b0, 5'h01, 8'h00, 8'h11, cyc, 1'b1);
    wait_gnt(0);
    req_a[0] = 3'b000;

    wait_idle(0);
    wait_idle(1);
    n = 0;
    while ((gq.size() != 0 || dq.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("leftover_gnt_expectations", gq.size(), 0);
    chk("leftover_done_expectations", dq.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
